// File: rtl/cgra_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cgra_pkg                                                                   |
// | Shared CGRA stream constants, the header magic and the arbiter state type. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cgra_pkg;

    // Stream geometry, kept in step with the CGRA stream interface definition
    localparam int unsigned phit_size     = 64;
    localparam int unsigned packet_length = 8;

    localparam logic [31:0] HDR_MAGIC = 32'h12345678;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational search for the first asserted request starting at ptr.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_vld
);

    // Walk from farthest to nearest so the request closest to ptr wins
    always_comb begin
        int idx;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (req[idx]) begin
                gnt_id  = idx[IDW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cgra_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cgra_stream_arbiter                                                        |
// | Packet-granular round-robin mux of NUM_SRC AXI-Stream sources onto the     |
// | CGRA input, with length checking and packet statistics.                   |
// | Optional header check/drop: define CGRA_ARB_HDR_CHECK_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cgra_stream_arbiter
    import cgra_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_SRC*phit_size-1:0]    s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC*phit_size/8-1:0]  s_axis_tkeep,
    output logic [phit_size-1:0]            m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [phit_size/8-1:0]          m_axis_tkeep,
    input  logic                            m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            busy,
    output logic [CNT_W-1:0]                pkt_count,
    output logic                            len_err,
    input  logic                            clr_err,
    output logic [CNT_W-1:0]                drop_count
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam int KW  = phit_size / 8;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IDW-1:0]       r_grant_id;
    logic [IDW-1:0]       r_rr_ptr;
    logic [31:0]          r_beat_cnt;
    logic [CNT_W-1:0]     r_pkt_count;
    logic                 r_len_err;
    logic                 r_busy;

    logic [IDW-1:0]       w_gnt_id;
    logic                 w_gnt_vld;
    logic [phit_size-1:0] w_src_data [NUM_SRC];
    logic [KW-1:0]        w_src_keep [NUM_SRC];
    logic [phit_size-1:0] w_sel_data;
    logic [KW-1:0]        w_sel_keep;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_hdr_pass;
    logic                 w_fwd_hs;
    logic                 w_drop_done;
    logic                 w_pkt_done;
    logic                 w_len_bad;
    logic [IDW-1:0]       w_rr_next;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
            assign w_src_data[g] = s_axis_tdata[g*phit_size +: phit_size];
            assign w_src_keep[g] = s_axis_tkeep[g*KW +: KW];
        end
    endgenerate

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req     (s_axis_tvalid),
        .ptr     (r_rr_ptr),
        .gnt_id  (w_gnt_id),
        .gnt_vld (w_gnt_vld)
    );

    assign w_sel_data  = w_src_data[r_grant_id];
    assign w_sel_keep  = w_src_keep[r_grant_id];
    assign w_sel_valid = s_axis_tvalid[r_grant_id];
    assign w_sel_last  = s_axis_tlast[r_grant_id];
    assign w_rr_next   = IDW'(wrap_inc(32'(r_grant_id), NUM_SRC));
    assign w_pkt_done  = w_fwd_hs & w_sel_last;
    assign w_len_bad   = (r_beat_cnt + 32'd1) != 32'(packet_length);

`ifdef CGRA_ARB_HDR_CHECK_EN
    // The first beat of a grant is held back until its header word is known good
    assign w_hdr_pass = (r_beat_cnt != 32'd0) || (w_sel_data[31:0] == HDR_MAGIC);
`else
    assign w_hdr_pass = 1'b1;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        w_fwd_hs      = 1'b0;
        w_drop_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = FWD;
                end
            end
            FWD: begin
                m_axis_tdata              = w_sel_data;
                m_axis_tkeep              = w_sel_keep;
                m_axis_tlast              = w_sel_last;
                m_axis_tvalid             = w_sel_valid & w_hdr_pass;
                s_axis_tready[r_grant_id] = m_axis_tready & w_hdr_pass;
                w_fwd_hs                  = w_sel_valid & w_hdr_pass & m_axis_tready;
                if (w_fwd_hs && w_sel_last) begin
                    w_state_nxt = IDLE;
                end
`ifdef CGRA_ARB_HDR_CHECK_EN
                else if (w_sel_valid && !w_hdr_pass) begin
                    w_state_nxt = DROP;
                end
`endif
            end
`ifdef CGRA_ARB_HDR_CHECK_EN
            DROP: begin
                s_axis_tready[r_grant_id] = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (r_state == IDLE && w_gnt_vld) begin
                r_grant_id <= w_gnt_id;
                r_beat_cnt <= '0;
            end else if (w_fwd_hs) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            if (w_pkt_done || w_drop_done) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // A length violation in the same cycle as clr_err must stay visible
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_pkt_count <= '0;
            r_len_err   <= 1'b0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_pkt_done && w_len_bad) begin
                r_len_err <= 1'b1;
            end else if (clr_err) begin
                r_len_err <= 1'b0;
            end
        end
    end

`ifdef CGRA_ARB_HDR_CHECK_EN
    logic [CNT_W-1:0] r_drop_count;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_drop_count <= '0;
        end else if (clr_err || w_drop_done) begin
            r_drop_count <= (clr_err ? '0 : r_drop_count) + {{(CNT_W-1){1'b0}}, w_drop_done};
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign pkt_count = r_pkt_count;
    assign len_err   = r_len_err;

endmodule
`default_nettype wire
